// File: rtl/md_stall_ctrl_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide controller.
// Op codes match the opE field driven by the decoder.
package md_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 4;

    function automatic logic is_div(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_stall_ctrl_if.sv
// Pipeline-facing bundle of the multiply/divide controller.
// The master is the pipeline (E/D stages), the slave is the controller.
interface md_stall_ctrl_if;
    logic        startE;
    logic [1:0]  opE;
    logic        mthiE;
    logic        mtloE;
    logic [31:0] srcAE;
    logic [31:0] srcBE;
    logic        mdUseD;
    logic        busy;
    logic        stall;
    logic        clrDE;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    modport master (
        output startE, opE, mthiE, mtloE, srcAE, srcBE, mdUseD,
        input  busy, stall, clrDE, hiOut, loOut
    );

    modport slave (
        input  startE, opE, mthiE, mtloE, srcAE, srcBE, mdUseD,
        output busy, stall, clrDE, hiOut, loOut
    );
endinterface

// File: rtl/md_stall_ctrl_calc.sv
// Combinational HI/LO result for the latched operands and op.
// Divisor is steered away from 0 and from the INT_MIN/-1 overflow case.
module md_calc
    import md_stall_ctrl_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output md_result_t  res_o,
    output logic        div_zero_o
);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_b;
    logic        [31:0] q_s;
    logic        [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic               div_ovf;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'b0, a_i} * {32'b0, b_i};

    // INT_MIN / -1 is evaluated as INT_MIN / 1: quotient INT_MIN, remainder 0.
    assign div_ovf    = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF) && (op_i == MD_DIV);
    assign div_zero_o = is_div(op_i) && (b_i == 32'd0);
    assign div_b      = (div_zero_o || div_ovf) ? 32'd1 : b_i;

    assign q_s = $signed(a_i) / $signed(div_b);
    assign r_s = $signed(a_i) % $signed(div_b);
    assign q_u = a_i / div_b;
    assign r_u = a_i % div_b;

    always_comb begin
        res_o = '0;
        unique case (op_i)
            MD_MULT:  res_o = prod_s;
            MD_MULTU: res_o = prod_u;
            MD_DIV:   res_o = '{hi: r_s, lo: q_s};
            MD_DIVU:  res_o = '{hi: r_u, lo: q_u};
            default:  res_o = '0;
        endcase
    end
endmodule

// File: rtl/md_stall_ctrl.sv
// Multiply/divide sequencer: busy counter, HI/LO ownership and the
// stall/bubble controls that keep HI/LO consumers out of E while busy.
module md_stall_ctrl
    import md_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
    input  logic            clk,
    input  logic            reset,
    md_stall_ctrl_if.slave  md_if
);
    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    md_op_e             op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    md_result_t         hilo_d;
    logic               div_zero;

    md_calc u_calc (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .res_o      (hilo_d),
        .div_zero_o (div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A start shadows any simultaneous mthi/mtlo.
                    if (md_if.startE) begin
                        op_q    <= md_op_e'(md_if.opE);
                        a_q     <= md_if.srcAE;
                        b_q     <= md_if.srcBE;
                        cnt_q   <= md_if.opE[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_q <= BUSY;
                    end else begin
                        if (md_if.mthiE) hi_q <= md_if.srcAE;
                        if (md_if.mtloE) lo_q <= md_if.srcAE;
                    end
                end
                BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        if (!div_zero) begin
                            hi_q <= hilo_d.hi;
                            lo_q <= hilo_d.lo;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md_if.busy  = (state_q == BUSY);
    assign md_if.stall = md_if.mdUseD & (md_if.startE | md_if.busy);
    assign md_if.clrDE = md_if.stall;
    assign md_if.hiOut = hi_q;
    assign md_if.loOut = lo_q;
endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl with a queue of expected HI/LO results.
module tb_md_stall_ctrl;
    import md_stall_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    md_stall_ctrl_if bus ();

    md_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_d,
                          input logic [31:0] ehi, input logic [31:0] elo, input int n);
        exp_t e;
        int   cnt;
        e.hi = ehi; e.lo = elo; e.cycles = n;
        sb.push_back(e);
        bus.startE = 1'b1; bus.opE = op; bus.srcAE = a; bus.srcBE = b; bus.mdUseD = use_d;
        @(negedge clk);
        chk({name, " stall_at_start"}, 32'(bus.stall), 32'(use_d));
        chk({name, " clrDE_at_start"}, 32'(bus.clrDE), 32'(use_d));
        chk({name, " busy_at_start"}, 32'(bus.busy), 32'd0);
        tick();
        bus.startE = 1'b0;
        bus.srcAE  = $urandom;
        bus.srcBE  = $urandom;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cnt++;
            chk({name, " stall_busy"}, 32'(bus.stall), 32'(use_d));
            chk({name, " clrDE_busy"}, 32'(bus.clrDE), 32'(use_d));
            tick();
        end
        e = sb.pop_front();
        chk({name, " busy_cycles"}, 32'(cnt), 32'(e.cycles));
        chk({name, " stall_after"}, 32'(bus.stall), 32'd0);
        chk({name, " hi"}, bus.hiOut, e.hi);
        chk({name, " lo"}, bus.loOut, e.lo);
        $display("op %-12s a=%08h b=%08h busy=%0d hi=%08h lo=%08h", name, a, b, cnt, bus.hiOut, bus.loOut);
        bus.mdUseD = 1'b0;
        tick();
    endtask

    task automatic mt(input logic to_hi, input logic [31:0] v);
        bus.mthiE = to_hi; bus.mtloE = ~to_hi; bus.srcAE = v;
        tick();
        bus.mthiE = 1'b0; bus.mtloE = 1'b0; bus.srcAE = $urandom;
        @(negedge clk);
        chk(to_hi ? "mthi value" : "mtlo value", to_hi ? bus.hiOut : bus.loOut, v);
        chk("mt busy", 32'(bus.busy), 32'd0);
        $display("mt%s value=%08h hi=%08h lo=%08h", to_hi ? "hi" : "lo", v, bus.hiOut, bus.loOut);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.startE = 1'b0; bus.opE = 2'b00; bus.mthiE = 1'b0; bus.mtloE = 1'b0;
        bus.srcAE = '0; bus.srcBE = '0; bus.mdUseD = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        chk("reset hi", bus.hiOut, 32'd0);
        chk("reset lo", bus.loOut, 32'd0);
        $display("reset busy=%0d hi=%08h lo=%08h", bus.busy, bus.hiOut, bus.loOut);
        tick();
        reset = 1'b0;
        bus.mdUseD = 1'b0;
        tick();

        run_op("mult_neg", MD_MULT,  32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 10);
        run_op("div_m7_2", MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("multu_big", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 32'hFFFF_FFFE, 5);

        mt(1'b1, 32'h1234_5678);
        run_op("mult_nouse", MD_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd1, 32'd0, 5);

        mt(1'b1, 32'h0000_000A);
        mt(1'b0, 32'h0000_000B);
        run_op("div_by_zero", MD_DIV, 32'd5, 32'd0, 1'b1, 32'h0000_000A, 32'h0000_000B, 10);
        run_op("div_intmin", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 10);
        run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD, 10);

        // Reset lands in the third busy cycle of a divide.
        mt(1'b1, 32'h0000_0055);
        mt(1'b0, 32'h0000_0066);
        bus.startE = 1'b1; bus.opE = MD_DIVU; bus.srcAE = 32'd100; bus.srcBE = 32'd7; bus.mdUseD = 1'b1;
        tick();
        bus.startE = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid busy_before", 32'(bus.busy), 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid busy", 32'(bus.busy), 32'd0);
        chk("rst_mid stall", 32'(bus.stall), 32'd0);
        chk("rst_mid hi", bus.hiOut, 32'd0);
        chk("rst_mid lo", bus.loOut, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        @(negedge clk);
        chk("rst_mid late_hi", bus.hiOut, 32'd0);
        chk("rst_mid late_lo", bus.loOut, 32'd0);
        chk("rst_mid late_busy", 32'(bus.busy), 32'd0);
        $display("reset_mid busy=%0d hi=%08h lo=%08h", bus.busy, bus.hiOut, bus.loOut);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
